// File: rtl/vfpu_round_pkg.sv
// Shared rounding-mode encodings and exponent constants for the vfpu rounding/packing logic.
package vfpu_round_pkg;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    function automatic int calc_bias(input int exp_w);
        return (32'sd1 <<< (exp_w - 32'sd1)) - 32'sd1;
    endfunction

    function automatic int calc_exp_inf(input int exp_w);
        return (32'sd1 <<< exp_w) - 32'sd1;
    endfunction

    function automatic int calc_exp_max_finite(input int exp_w);
        return (32'sd1 <<< exp_w) - 32'sd2;
    endfunction

endpackage

// File: rtl/round_incr.sv
// Round-increment decision from rounding mode, sign, result LSB and guard/round/sticky bits.
module round_incr
    import vfpu_round_pkg::*;
(
    input  logic [2:0] rmode,
    input  logic       sign,
    input  logic       lsb,
    input  logic [2:0] grs,
    output logic       inc
);

    logic nx_s;

    // Increment select; unused encodings fall back to round-to-nearest-even
    always_comb begin
        nx_s = |grs;
        case (rmode)
            RM_RNE:  inc = grs[2] & (grs[1] | grs[0] | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = nx_s & sign;
            RM_RUP:  inc = nx_s & ~sign;
            RM_RMM:  inc = grs[2];
            default: inc = grs[2] & (grs[1] | grs[0] | lsb);
        endcase
    end

endmodule

// File: rtl/round_stage_pipe.sv
// Two-stage FP round-and-pack pipeline with valid/ready handshake between normaliser and writeback FIFO.
module round_stage_pipe
    import vfpu_round_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     nj_mode,
    input  logic [2:0]               rmode,
    input  logic                     s_final,
    input  logic [EXP_W+1:0]         exp_norm,
    input  logic [MAN_W+3:0]         frac_inter_norm,
    input  logic                     denorm_m,
    input  logic                     zero_m,
    input  logic [TAG_W-1:0]         tag_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     res,
    output logic                     flag_of,
    output logic                     flag_uf,
    output logic                     flag_nx,
    output logic [TAG_W-1:0]         tag_out
);

    localparam logic [EXP_W+1:0] BIAS      = (EXP_W+2)'(calc_bias(EXP_W));
    localparam logic [EXP_W+1:0] EXP_INF_W = (EXP_W+2)'(calc_exp_inf(EXP_W));
    localparam logic [EXP_W-1:0] EXP_MAXF  = EXP_W'(calc_exp_max_finite(EXP_W));

    logic s1_adv_s, s2_adv_s;
    logic [MAN_W:0]   frac_z1_s;
    logic [2:0]       grs_s;
    logic             inc_s;
    logic [MAN_W+1:0] sum_s;

    logic                 s1_valid_r, s1_sign_r, s1_carry_r, s1_nx_r;
    logic                 s1_denorm_r, s1_zero_r, s1_nj_r;
    logic [EXP_W+1:0]     s1_exp_r;
    logic [MAN_W:0]       s1_frac_r;
    logic [2:0]           s1_rmode_r;
    logic [TAG_W-1:0]     s1_tag_r;

    logic signed [EXP_W+1:0] e_s;
    logic                    ovf_s, ovf_max_s;
    logic [EXP_W+MAN_W:0]    res_nxt_s;
    logic                    of_nxt_s, uf_nxt_s, nx_nxt_s;

    logic                    out_valid_r, of_r, uf_r, nx_r;
    logic [EXP_W+MAN_W:0]    res_r;
    logic [TAG_W-1:0]        tag_r;

    assign s2_adv_s = ~out_valid_r | out_ready;
    assign s1_adv_s = ~s1_valid_r | s2_adv_s;
    assign in_ready = s1_adv_s;

    assign frac_z1_s = frac_inter_norm[MAN_W+3:3];
    assign grs_s     = frac_inter_norm[2:0];

    round_incr u_round_incr (
        .rmode (rmode),
        .sign  (s_final),
        .lsb   (frac_z1_s[0]),
        .grs   (grs_s),
        .inc   (inc_s)
    );

    assign sum_s = {1'b0, frac_z1_s} + {{(MAN_W+1){1'b0}}, inc_s};

    // Stage 1: capture rounded fraction and operation context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_sign_r   <= 1'b0;
            s1_exp_r    <= '0;
            s1_frac_r   <= '0;
            s1_carry_r  <= 1'b0;
            s1_nx_r     <= 1'b0;
            s1_denorm_r <= 1'b0;
            s1_zero_r   <= 1'b0;
            s1_nj_r     <= 1'b0;
            s1_rmode_r  <= 3'd0;
            s1_tag_r    <= '0;
        end else if (s1_adv_s) begin
            s1_valid_r  <= in_valid;
            s1_sign_r   <= s_final;
            s1_exp_r    <= exp_norm;
            s1_frac_r   <= sum_s[MAN_W:0];
            s1_carry_r  <= sum_s[MAN_W+1];
            s1_nx_r     <= |grs_s;
            s1_denorm_r <= denorm_m;
            s1_zero_r   <= zero_m;
            s1_nj_r     <= nj_mode;
            s1_rmode_r  <= rmode;
            s1_tag_r    <= tag_in;
        end
    end

    // Biased exponent and overflow detect; a denormal rounding into the hidden bit becomes the smallest normal
    always_comb begin
        if (s1_denorm_r) begin
            e_s = $signed({{(EXP_W+1){1'b0}}, s1_carry_r | s1_frac_r[MAN_W]});
        end else begin
            e_s = $signed(s1_exp_r) + $signed(BIAS) + $signed({{(EXP_W+1){1'b0}}, s1_carry_r});
        end
        ovf_s = ~s1_denorm_r & (e_s >= $signed(EXP_INF_W));
    end

    // Overflow saturates to max-finite when the mode rounds toward zero for this sign
    always_comb begin
        case (s1_rmode_r)
            RM_RTZ:  ovf_max_s = 1'b1;
            RM_RDN:  ovf_max_s = ~s1_sign_r;
            RM_RUP:  ovf_max_s = s1_sign_r;
            default: ovf_max_s = 1'b0;
        endcase
    end

    // Result packing in priority order: zero, flushed denormal, overflow, normal/denormal
    always_comb begin
        res_nxt_s = '0;
        of_nxt_s  = 1'b0;
        uf_nxt_s  = 1'b0;
        nx_nxt_s  = 1'b0;
        if (s1_zero_r) begin
            res_nxt_s = '0;
        end else if (s1_nj_r & s1_denorm_r) begin
            res_nxt_s = {s1_sign_r, {(EXP_W+MAN_W){1'b0}}};
            uf_nxt_s  = 1'b1;
            nx_nxt_s  = 1'b1;
        end else if (ovf_s) begin
            of_nxt_s = 1'b1;
            nx_nxt_s = 1'b1;
            if (ovf_max_s) begin
                res_nxt_s = {s1_sign_r, EXP_MAXF, {MAN_W{1'b1}}};
            end else begin
                res_nxt_s = {s1_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end else begin
            res_nxt_s = {s1_sign_r, e_s[EXP_W-1:0], s1_frac_r[MAN_W-1:0]};
            nx_nxt_s  = s1_nx_r;
            uf_nxt_s  = s1_denorm_r & s1_nx_r;
        end
    end

    // Stage 2: output registers, held while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            res_r       <= '0;
            of_r        <= 1'b0;
            uf_r        <= 1'b0;
            nx_r        <= 1'b0;
            tag_r       <= '0;
        end else if (s2_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                res_r <= res_nxt_s;
                of_r  <= of_nxt_s;
                uf_r  <= uf_nxt_s;
                nx_r  <= nx_nxt_s;
                tag_r <= s1_tag_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign res       = res_r;
    assign flag_of   = of_r;
    assign flag_uf   = uf_r;
    assign flag_nx   = nx_r;
    assign tag_out   = tag_r;

endmodule

// File: tb/tb_round_stage_pipe.sv
// Bench for round_stage_pipe: directed vector table, backpressure/reset sequences, random traffic vs. arithmetic model.
module tb_round_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, nj_mode, s_final, denorm_m, zero_m;
    logic [2:0]  rmode;
    logic [9:0]  exp_norm;
    logic [26:0] frac_inter_norm;
    logic [3:0]  tag_in, tag_out;
    logic        out_valid, out_ready, flag_of, flag_uf, flag_nx;
    logic [31:0] res;

    always #5 clk = ~clk;

    round_stage_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .nj_mode(nj_mode), .rmode(rmode), .s_final(s_final), .exp_norm(exp_norm),
        .frac_inter_norm(frac_inter_norm), .denorm_m(denorm_m), .zero_m(zero_m),
        .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready), .res(res),
        .flag_of(flag_of), .flag_uf(flag_uf), .flag_nx(flag_nx), .tag_out(tag_out)
    );

    typedef struct {
        logic [31:0] res;
        logic        of, uf, nx;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic        s;
        logic [9:0]  en;
        logic [26:0] fr;
        logic        dn, z, nj;
        logic [2:0]  rm;
        logic [31:0] res;
        logic        of, uf, nx;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vt[12];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          use_model;
    exp_t        tbl_exp;
    bit          last_acc;
    bit          hold_chk = 1'b0;
    logic [31:0] hold_res;
    logic [6:0]  hold_misc;
    int          sent;

    // Reference: round the integer significand by the IEEE rules, then classify.
    function automatic exp_t model(input logic s, input logic [9:0] en, input logic [26:0] fr,
                                   input logic dn, input logic z, input logic nj,
                                   input logic [2:0] rm, input logic [3:0] tg);
        exp_t r;
        int unsigned mant, rem, rounded;
        int e;
        logic up, nx, to_zero;
        r.tag = tg; r.res = 32'd0; r.of = 1'b0; r.uf = 1'b0; r.nx = 1'b0;
        mant = 32'(fr[26:3]);
        rem  = 32'(fr[2:0]);
        nx   = (rem != 32'd0);
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = nx && s;
            3'd3:    up = nx && !s;
            3'd4:    up = (rem >= 32'd4);
            default: up = (rem > 32'd4) || (rem == 32'd4 && mant[0]);
        endcase
        rounded = mant + 32'(up);
        if (z) return r;
        if (dn && nj) begin
            r.res = {s, 31'd0}; r.uf = 1'b1; r.nx = 1'b1;
            return r;
        end
        r.nx = nx;
        if (dn) begin
            r.res = {s, ((rounded >> 23) != 32'd0) ? 8'd1 : 8'd0, 23'(rounded)};
            r.uf  = nx;
            return r;
        end
        e = int'($signed(en)) + 127 + (((rounded >> 24) != 32'd0) ? 1 : 0);
        if (e >= 255) begin
            r.of = 1'b1; r.nx = 1'b1;
            to_zero = (rm == 3'd1) || (rm == 3'd2 && !s) || (rm == 3'd3 && s);
            r.res = to_zero ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'h000000};
        end else begin
            r.res = {s, 8'(e), 23'(rounded)};
        end
        return r;
    endfunction

    task automatic cmp_out(input exp_t e, input string nm);
        n_cmp++;
        if (res !== e.res || flag_of !== e.of || flag_uf !== e.uf || flag_nx !== e.nx || tag_out !== e.tag) begin
            n_bad++;
            $display("FAIL %s: got res=%h of=%b uf=%b nx=%b tag=%h, want res=%h of=%b uf=%b nx=%b tag=%h",
                     nm, res, flag_of, flag_uf, flag_nx, tag_out, e.res, e.of, e.uf, e.nx, e.tag);
        end
    endtask

    task automatic cmp_bit(input logic act, input logic want, input string nm);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", nm, act, want);
        end
    endtask

    // One clock: inputs already driven at the negedge; check, score, then advance to next negedge.
    task automatic step();
        exp_t e;
        logic want_rdy;
        #1;
        last_acc = 1'b0;
        if (!rst) begin
            want_rdy = out_ready || (sb_q.size() < 2);
            cmp_bit(in_ready, want_rdy, "in_ready");
            if (hold_chk) begin
                n_cmp++;
                if (out_valid !== 1'b1 || res !== hold_res ||
                    {flag_of, flag_uf, flag_nx, tag_out} !== hold_misc) begin
                    n_bad++;
                    $display("FAIL stall_hold: got v=%b res=%h misc=%h, want v=1 res=%h misc=%h",
                             out_valid, res, {flag_of, flag_uf, flag_nx, tag_out}, hold_res, hold_misc);
                end
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_out: got res=%h tag=%h, want no output", res, tag_out);
                end else begin
                    cmp_out(sb_q.pop_front(), "result");
                end
            end
            if (in_valid && in_ready) begin
                if (use_model)
                    e = model(s_final, exp_norm, frac_inter_norm, denorm_m, zero_m, nj_mode, rmode, tag_in);
                else begin
                    e = tbl_exp;
                    e.tag = tag_in;
                end
                sb_q.push_back(e);
                last_acc = 1'b1;
            end
            hold_chk  = out_valid && !out_ready;
            hold_res  = res;
            hold_misc = {flag_of, flag_uf, flag_nx, tag_out};
        end
        @(negedge clk);
    endtask

    task automatic rand_op();
        s_final  = 1'($urandom_range(0, 1));
        zero_m   = ($urandom_range(0, 15) == 0);
        denorm_m = ($urandom_range(0, 7) == 0);
        nj_mode  = 1'($urandom_range(0, 1));
        rmode    = 3'($urandom_range(0, 7));
        exp_norm = 10'($urandom_range(0, 255)) - 10'd126;
        frac_inter_norm = 27'($urandom);
        if ($urandom_range(0, 3) == 0) frac_inter_norm[2:0] = 3'b100;
        if ($urandom_range(0, 7) == 0) frac_inter_norm[25:3] = 23'h7FFFFF;
        frac_inter_norm[26] = !denorm_m;
        tag_in = 4'($urandom);
    endtask

    task automatic drain(input string nm);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d pending, want 0", nm, sb_q.size());
        end
    endtask

    initial begin
        vt[0]  = '{1'b0, 10'd0,   27'h4000004, 1'b0, 1'b0, 1'b0, 3'd0, 32'h3F800000, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{1'b0, 10'd0,   27'h400000C, 1'b0, 1'b0, 1'b0, 3'd0, 32'h3F800002, 1'b0, 1'b0, 1'b1};
        vt[2]  = '{1'b0, 10'd0,   27'h7FFFFFE, 1'b0, 1'b0, 1'b0, 3'd0, 32'h40000000, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 10'd128, 27'h4000000, 1'b0, 1'b0, 1'b0, 3'd0, 32'h7F800000, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 10'd128, 27'h4000000, 1'b0, 1'b0, 1'b0, 3'd1, 32'h7F7FFFFF, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 10'd128, 27'h4000000, 1'b0, 1'b0, 1'b0, 3'd3, 32'hFF7FFFFF, 1'b1, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 10'd128, 27'h4000000, 1'b0, 1'b0, 1'b0, 3'd2, 32'hFF800000, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 10'd0,   27'h3FFFFFC, 1'b1, 1'b0, 1'b0, 3'd0, 32'h00800000, 1'b0, 1'b1, 1'b1};
        vt[8]  = '{1'b0, 10'd0,   27'h3FFFFFC, 1'b1, 1'b0, 1'b1, 3'd0, 32'h00000000, 1'b0, 1'b1, 1'b1};
        vt[9]  = '{1'b1, 10'd5,   27'h4000005, 1'b0, 1'b1, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b0, 10'd0,   27'h4000004, 1'b0, 1'b0, 1'b0, 3'd4, 32'h3F800001, 1'b0, 1'b0, 1'b1};
        vt[11] = '{1'b0, 10'd0,   27'h400000C, 1'b0, 1'b0, 1'b0, 3'd6, 32'h3F800002, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; nj_mode = 1'b0; rmode = 3'd0;
        s_final = 1'b0; exp_norm = 10'd0; frac_inter_norm = 27'd0; denorm_m = 1'b0;
        zero_m = 1'b0; tag_in = 4'd0; use_model = 1'b1;
        repeat (2) @(negedge clk);
        cmp_bit(out_valid, 1'b0, "reset_out_valid");
        n_cmp++;
        if (res !== 32'd0 || {flag_of, flag_uf, flag_nx} !== 3'b000 || tag_out !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got res=%h flags=%b tag=%h, want all zero",
                     res, {flag_of, flag_uf, flag_nx}, tag_out);
        end
        rst = 1'b0;

        // Directed vectors, streamed back to back
        use_model = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_final = vt[i].s; exp_norm = vt[i].en; frac_inter_norm = vt[i].fr;
            denorm_m = vt[i].dn; zero_m = vt[i].z; nj_mode = vt[i].nj; rmode = vt[i].rm;
            tag_in = 4'(i);
            in_valid = 1'b1;
            tbl_exp.res = vt[i].res; tbl_exp.of = vt[i].of; tbl_exp.uf = vt[i].uf; tbl_exp.nx = vt[i].nx;
            tbl_exp.tag = 4'd0;
            step();
        end
        drain("table");
        use_model = 1'b1;

        // Backpressure: six ops, downstream stalled for cycles 3-6
        sent = 0;
        for (int k = 0; k < 30; k++) begin
            if (sent < 6) begin
                rand_op();
                tag_in = 4'(8 + sent);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(k >= 3 && k <= 6);
            if (k == 3) begin
                #1;
                cmp_bit(in_ready, 1'b0, "bp_in_ready_low");
                #(-0);
            end
            step();
            if (last_acc) sent++;
        end
        drain("backpressure");

        // Random traffic with random stalls
        for (int k = 0; k < 400; k++) begin
            rand_op();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain("random");

        // Reset with two ops in flight
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rand_op();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        cmp_bit(out_valid, 1'b0, "reset_mid_out_valid");
        sb_q.delete();
        hold_chk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmp_bit(out_valid, 1'b0, "post_reset_no_stale");
            step();
        end
        rand_op();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cmp_bit(out_valid, 1'b0, "latency_cycle1");
        step();
        cmp_bit(out_valid, 1'b1, "latency_cycle2");
        drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
